// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM session arbiter.
package atm_pkg;

    localparam int DIG_W   = 4;
    localparam int MONTO_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SESION = 2'd1,
        CIERRE = 2'd2
    } estado_t;

    typedef logic [1:0] motivo_t;

    localparam motivo_t MOT_OK      = 2'd0;
    localparam motivo_t MOT_FONDOS  = 2'd1;
    localparam motivo_t MOT_BLOQUEO = 2'd2;
    localparam motivo_t MOT_TIMEOUT = 2'd3;

endpackage

// File: rtl/arbitro_rr.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module arbitro_rr #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  pendiente,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] ganador,
    output logic          valido
);

    // Scan N positions starting at ptr; the first hit wins.
    always_comb begin
        int idx;
        ganador = '0;
        valido  = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!valido && pendiente[idx]) begin
                valido  = 1'b1;
                ganador = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/atm_arbitro_sesion.sv
// Shares one cajero_atm core among N_TERM terminals, one full session at a time.
// Session shape: grant cycle (tarjeta_recibida) .. close cycle (fin_sesion) ->
// CIERRE guard cycle -> IDLE, so the next tarjeta_recibida lands 3 cycles after fin_sesion.
module atm_arbitro_sesion
    import atm_pkg::*;
#(
    parameter int N_TERM         = 2,
    parameter int TIMEOUT_CICLOS = 1000,
    localparam int IDX_W = (N_TERM > 1) ? $clog2(N_TERM) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_TERM-1:0]          tarjeta_req,
    input  logic [DIG_W*N_TERM-1:0]    digito_in,
    input  logic [N_TERM-1:0]          digito_stb_in,
    input  logic [N_TERM-1:0]          tipo_trans_in,
    input  logic [MONTO_W*N_TERM-1:0]  monto_in,
    input  logic [N_TERM-1:0]          monto_stb_in,
    input  logic                       balance_stb,
    input  logic                       fondos_insuficientes,
    input  logic                       bloqueo,
    output logic                       tarjeta_recibida,
    output logic [DIG_W-1:0]           digito,
    output logic                       digito_stb,
    output logic                       tipo_trans,
    output logic [MONTO_W-1:0]         monto,
    output logic                       monto_stb,
    output logic [N_TERM-1:0]          grant,
    output logic                       ocupado,
    output logic [N_TERM-1:0]          pendiente,
    output logic [N_TERM-1:0]          fin_sesion,
    output motivo_t                    motivo
);

    localparam int CNT_W = $clog2(TIMEOUT_CICLOS);

    estado_t            estado;
    logic [IDX_W-1:0]   own;
    logic [IDX_W-1:0]   ptr;
    logic [CNT_W-1:0]   cnt;
    logic               cerrando;   // high during the close cycle (fin_sesion visible)

    logic [IDX_W-1:0]   ganador;
    logic               valido;
    logic               own_dstb;
    logic               own_mstb;
    logic               evento;
    motivo_t            mot_sel;
    logic [N_TERM-1:0]  pend_nxt;

    arbitro_rr #(.N(N_TERM)) u_rr (
        .pendiente (pendiente),
        .ptr       (ptr),
        .ganador   (ganador),
        .valido    (valido)
    );

    assign own_dstb = digito_stb_in[own];
    assign own_mstb = monto_stb_in[own];

    // Close event with fixed priority: bloqueo > fondos > balance > idle timeout.
    always_comb begin
        evento  = 1'b1;
        mot_sel = MOT_OK;
        if (bloqueo)
            mot_sel = MOT_BLOQUEO;
        else if (fondos_insuficientes)
            mot_sel = MOT_FONDOS;
        else if (balance_stb)
            mot_sel = MOT_OK;
        else if (cnt == CNT_W'(TIMEOUT_CICLOS - 1))
            mot_sel = MOT_TIMEOUT;
        else
            evento = 1'b0;
    end

    // Pending requests: the owner's card pulses are ignored while it holds the
    // core, and the bit being granted clears even if re-requested that cycle.
    always_comb begin
        pend_nxt = pendiente | tarjeta_req;
        if (estado == SESION)
            pend_nxt[own] = pendiente[own];
        if (estado == IDLE && valido)
            pend_nxt[ganador] = 1'b0;
    end

    // Latch pending card requests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pendiente <= '0;
        else
            pendiente <= pend_nxt;
    end

    // Session FSM with registered outputs and keypad forwarding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado           <= IDLE;
            own              <= '0;
            ptr              <= '0;
            cnt              <= '0;
            cerrando         <= 1'b0;
            grant            <= '0;
            ocupado          <= 1'b0;
            tarjeta_recibida <= 1'b0;
            fin_sesion       <= '0;
            motivo           <= MOT_OK;
            digito           <= '0;
            digito_stb       <= 1'b0;
            tipo_trans       <= 1'b0;
            monto            <= '0;
            monto_stb        <= 1'b0;
        end else begin
            tarjeta_recibida <= 1'b0;
            fin_sesion       <= '0;
            motivo           <= MOT_OK;
            digito_stb       <= 1'b0;
            monto_stb        <= 1'b0;
            case (estado)
                IDLE: begin
                    if (valido) begin
                        own              <= ganador;
                        grant            <= N_TERM'(1) << ganador;
                        tarjeta_recibida <= 1'b1;
                        ocupado          <= 1'b1;
                        cnt              <= '0;
                        cerrando         <= 1'b0;
                        estado           <= SESION;
                    end
                end
                SESION: begin
                    if (cerrando) begin
                        // Close cycle done: release the terminal, keep core busy one more cycle.
                        cerrando <= 1'b0;
                        grant    <= '0;
                        estado   <= CIERRE;
                    end else if (evento) begin
                        // Coincident owner strobes are dropped here.
                        fin_sesion <= N_TERM'(1) << own;
                        motivo     <= mot_sel;
                        cerrando   <= 1'b1;
                    end else begin
                        digito_stb <= own_dstb;
                        monto_stb  <= own_mstb;
                        if (own_dstb)
                            digito <= digito_in[int'(own)*DIG_W +: DIG_W];
                        if (own_mstb) begin
                            monto      <= monto_in[int'(own)*MONTO_W +: MONTO_W];
                            tipo_trans <= tipo_trans_in[own];
                        end
                        cnt <= (own_dstb || own_mstb) ? '0 : cnt + CNT_W'(1);
                    end
                end
                CIERRE: begin
                    ptr     <= IDX_W'((int'(own) + 1) % N_TERM);
                    ocupado <= 1'b0;
                    estado  <= IDLE;
                end
                default: estado <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_atm_arbitro_sesion.sv
// Directed self-checking bench for atm_arbitro_sesion (2 terminals, timeout 20).
module tb_atm_arbitro_sesion;

    localparam int N  = 2;
    localparam int TO = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  tarjeta_req;
    logic [4*N-1:0]  digito_in;
    logic [N-1:0]  digito_stb_in;
    logic [N-1:0]  tipo_trans_in;
    logic [32*N-1:0] monto_in;
    logic [N-1:0]  monto_stb_in;
    logic          balance_stb, fondos_insuficientes, bloqueo;
    logic          tarjeta_recibida, digito_stb, tipo_trans, monto_stb, ocupado;
    logic [3:0]    digito;
    logic [31:0]   monto;
    logic [N-1:0]  grant, pendiente, fin_sesion;
    logic [1:0]    motivo;

    int n_chk  = 0;
    int n_pass = 0;
    int n;

    atm_arbitro_sesion #(.N_TERM(N), .TIMEOUT_CICLOS(TO)) dut (
        .clk(clk), .reset(reset),
        .tarjeta_req(tarjeta_req), .digito_in(digito_in), .digito_stb_in(digito_stb_in),
        .tipo_trans_in(tipo_trans_in), .monto_in(monto_in), .monto_stb_in(monto_stb_in),
        .balance_stb(balance_stb), .fondos_insuficientes(fondos_insuficientes), .bloqueo(bloqueo),
        .tarjeta_recibida(tarjeta_recibida), .digito(digito), .digito_stb(digito_stb),
        .tipo_trans(tipo_trans), .monto(monto), .monto_stb(monto_stb),
        .grant(grant), .ocupado(ocupado), .pendiente(pendiente),
        .fin_sesion(fin_sesion), .motivo(motivo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Outputs sampled 1 time unit after the edge; inputs set here feed the next edge.
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_tarjeta(input int lim, output int cnt);
        cnt = 0;
        while (!tarjeta_recibida && cnt < lim) begin tick(); cnt++; end
        if (!tarjeta_recibida) chk("tarjeta_wait_bound", 64'(0), 64'(1));
    endtask

    task automatic wait_fin(input int lim, output int cnt);
        cnt = 0;
        while (fin_sesion == '0 && cnt < lim) begin tick(); cnt++; end
        if (fin_sesion == '0) chk("fin_wait_bound", 64'(0), 64'(1));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        tarjeta_req = '0; digito_in = '0; digito_stb_in = '0; tipo_trans_in = '0;
        monto_in = '0; monto_stb_in = '0;
        balance_stb = 1'b0; fondos_insuficientes = 1'b0; bloqueo = 1'b0;
        repeat (2) tick();
        chk("reset_outs", 64'({tarjeta_recibida, digito, digito_stb, tipo_trans, monto_stb,
                               grant, ocupado, pendiente, fin_sesion, motivo}), 64'(0));
        chk("reset_monto", 64'(monto), 64'(0));
        reset = 1'b0;

        // ---- single session on T0 ----
        tarjeta_req = 2'b01; tick(); tarjeta_req = '0;
        chk("s1_pend", 64'(pendiente), 64'(2'b01));
        tick();
        chk("s1_tarjeta", 64'(tarjeta_recibida), 64'(1));
        chk("s1_grant", 64'(grant), 64'(2'b01));
        chk("s1_pend_clr", 64'(pendiente), 64'(0));
        for (int d = 1; d <= 4; d++) begin
            digito_in[3:0] = 4'(d); digito_stb_in = 2'b01;
            tick();
            chk("s1_dstb", 64'(digito_stb), 64'(1));
            chk("s1_dig", 64'(digito), 64'(d));
        end
        digito_stb_in = '0; tick();
        chk("s1_dstb_off", 64'(digito_stb), 64'(0));
        chk("s1_dig_hold", 64'(digito), 64'(4));
        chk("s1_tarj_once", 64'(tarjeta_recibida), 64'(0));
        monto_in[31:0] = 32'd100; tipo_trans_in = 2'b00; monto_stb_in = 2'b01; tick();
        monto_stb_in = '0;
        chk("s1_mstb", 64'(monto_stb), 64'(1));
        chk("s1_monto", 64'(monto), 64'(100));
        chk("s1_tipo", 64'(tipo_trans), 64'(0));
        balance_stb = 1'b1; tick(); balance_stb = 1'b0;
        chk("s1_fin", 64'(fin_sesion), 64'(2'b01));
        chk("s1_mot", 64'(motivo), 64'(0));
        tick();
        chk("s1_cierre_grant", 64'(grant), 64'(0));
        chk("s1_cierre_ocup", 64'(ocupado), 64'(1));
        chk("s1_fin_pulse", 64'(fin_sesion), 64'(0));
        tick();
        chk("s1_idle_ocup", 64'(ocupado), 64'(0));

        // ---- contention from pointer 0 ----
        do_reset();
        tarjeta_req = 2'b11; tick(); tarjeta_req = '0;
        chk("c_pend", 64'(pendiente), 64'(2'b11));
        tick();
        chk("c_grant_t0", 64'(grant), 64'(2'b01));
        chk("c_pend_t1", 64'(pendiente), 64'(2'b10));
        digito_in[7:4] = 4'd9; digito_stb_in = 2'b10; tick(); digito_stb_in = '0;
        chk("c_t1_drop", 64'(digito_stb), 64'(0));
        // owner strobe coincident with close is dropped
        digito_in[3:0] = 4'd5; digito_stb_in = 2'b01; balance_stb = 1'b1; tick();
        digito_stb_in = '0; balance_stb = 1'b0;
        chk("c_fin_t0", 64'(fin_sesion), 64'(2'b01));
        chk("c_coinc_drop", 64'(digito_stb), 64'(0));
        wait_tarjeta(10, n);
        chk("c_spacing", 64'(n), 64'(3));
        chk("c_grant_t1", 64'(grant), 64'(2'b10));

        // ---- T1 session: owner re-insert ignored, T0 re-inserts, bloqueo beats balance ----
        tarjeta_req = 2'b11; tick(); tarjeta_req = '0;
        chk("f_pend_own_ign", 64'(pendiente), 64'(2'b01));
        bloqueo = 1'b1; balance_stb = 1'b1; tick(); bloqueo = 1'b0; balance_stb = 1'b0;
        chk("p_fin_t1", 64'(fin_sesion), 64'(2'b10));
        chk("p_mot_bloq", 64'(motivo), 64'(2));
        tick();
        tarjeta_req = 2'b10; tick(); tarjeta_req = '0;
        chk("f_pend_both", 64'(pendiente), 64'(2'b11));
        tick();
        chk("f_grant_t0", 64'(grant), 64'(2'b01));
        chk("f_tarj_t0", 64'(tarjeta_recibida), 64'(1));

        // ---- T0 withdraw 1000 rejected ----
        monto_in[31:0] = 32'd1000; tipo_trans_in = 2'b01; monto_stb_in = 2'b01; tick();
        monto_stb_in = '0;
        chk("w_monto", 64'(monto), 64'(1000));
        chk("w_tipo", 64'(tipo_trans), 64'(1));
        fondos_insuficientes = 1'b1; tick(); fondos_insuficientes = 1'b0;
        chk("w_fin", 64'(fin_sesion), 64'(2'b01));
        chk("w_mot", 64'(motivo), 64'(1));
        tick();
        tarjeta_req = 2'b01; tick(); tarjeta_req = '0;
        wait_tarjeta(10, n);
        chk("f_grant_t1b", 64'(grant), 64'(2'b10));

        // ---- T1 idle timeout ----
        wait_fin(40, n);
        chk("t_cycles", 64'(n), 64'(TO));
        chk("t_fin", 64'(fin_sesion), 64'(2'b10));
        chk("t_mot", 64'(motivo), 64'(3));
        wait_tarjeta(10, n);
        chk("t_grant_t0", 64'(grant), 64'(2'b01));

        // ---- T0 timeout pushed out by a digit 9 cycles after grant ----
        repeat (9) tick();
        digito_in[3:0] = 4'd7; digito_stb_in = 2'b01; tick(); digito_stb_in = '0;
        chk("t2_dig", 64'(digito), 64'(7));
        wait_fin(40, n);
        chk("t2_cycles", 64'(n + 10), 64'(30));
        chk("t2_mot", 64'(motivo), 64'(3));

        // ---- reset mid-session with T1 owning and T0 pending ----
        tick();
        tarjeta_req = 2'b10; tick(); tarjeta_req = '0;
        tick();
        chk("r_grant_t1", 64'(grant), 64'(2'b10));
        tarjeta_req = 2'b01; tick(); tarjeta_req = '0;
        chk("r_pend_t0", 64'(pendiente), 64'(2'b01));
        #3 reset = 1'b1;
        #1;
        chk("r_async_outs", 64'({tarjeta_recibida, grant, ocupado, pendiente, fin_sesion, motivo}), 64'(0));
        tick();
        reset = 1'b0;
        repeat (4) tick();
        chk("r_no_grant", 64'({grant, pendiente, fin_sesion, ocupado}), 64'(0));
        tarjeta_req = 2'b01; tick(); tarjeta_req = '0;
        tick();
        chk("r_new_grant", 64'(grant), 64'(2'b01));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
